// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction-fetch unit.
package fetch_pkg;

   // One queued fetch result: byte PC of the word and the word itself.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Sequential fetch advances one 32-bit word at a time.
   localparam logic [31:0] FETCH_STEP = 32'd4;

   // Redirect targets are word aligned; the low two bits are ignored.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous queue of fetch entries with wrap-bit pointers and a flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  fetch_entry_t             i_din,
   output fetch_entry_t             o_dout,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]  r_wr_ptr;
   logic [PW:0]  r_rd_ptr;
   fetch_entry_t r_mem [DEPTH];

   // Storage and pointers; storage is cleared on reset so the head reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_din;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   assign o_dout  = r_mem[r_rd_ptr[PW-1:0]];
   assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/rv32_fetch_queue.sv
// Prefetching fetch unit: streams imem reads into a queue of {pc, instr}
// pairs for decode, with redirect flushing the queue and any in-flight read.
module rv32_fetch_queue
   import fetch_pkg::*;
#(
   parameter int          ADDR_WIDTH_I = 10,
   parameter int          DATA_WIDTH_I = 32,
   parameter int          DEPTH        = 4,
   parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fetch_en,
   output logic                      imem_req,
   output logic [ADDR_WIDTH_I-1:0]   imem_addr,
   input  logic [DATA_WIDTH_I-1:0]   data_imem,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [DATA_WIDTH_I-1:0]   instr,
   output logic [31:0]               instr_pc,
   input  logic                      redirect_valid,
   input  logic [31:0]               redirect_pc,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int             CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]    LP_DEPTH = (CW + 1)'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_pending_pc;
   logic          r_pending;

   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic [CW:0]   w_credit;
   fetch_entry_t  w_push_entry;
   fetch_entry_t  w_head;

   // A redirect wins over consumption: the head is not taken that cycle.
   assign w_pop    = instr_valid && instr_ready && !redirect_valid;
   // Slots already committed once this cycle settles; a new read may only
   // be issued if its data is guaranteed a free entry.
   assign w_credit = {1'b0, count} + {{CW{1'b0}}, r_pending} - {{CW{1'b0}}, w_pop};
   assign w_issue  = !rst && fetch_en && !redirect_valid && (w_credit < LP_DEPTH);
   assign w_push   = r_pending && !redirect_valid;

   assign w_push_entry.pc    = r_pending_pc;
   assign w_push_entry.instr = data_imem;

   // Fetch address and in-flight read tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc   <= RESET_PC;
         r_pending    <= 1'b0;
         r_pending_pc <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= align_pc(redirect_pc);
         r_pending  <= 1'b0;
      end else begin
         r_pending <= w_issue;
         if (w_issue) begin
            r_pending_pc <= r_fetch_pc;
            r_fetch_pc   <= r_fetch_pc + FETCH_STEP;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect_valid),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_push_entry),
      .o_dout  (w_head),
      .o_count (count)
   );

   assign imem_req    = w_issue;
   assign imem_addr   = r_fetch_pc[ADDR_WIDTH_I+1:2];
   assign instr_valid = (count != '0);
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Self-checking bench for rv32_fetch_queue: a queue-level reference model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_rv32_fetch_queue;

   localparam int          AW    = 10;
   localparam int          DW    = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fetch_en = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] data_imem = '0;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic [DW-1:0] instr;
   logic [31:0]   instr_pc;
   logic          redirect_valid = 1'b0;
   logic [31:0]   redirect_pc = '0;
   logic [2:0]    count;

   rv32_fetch_queue #(
      .ADDR_WIDTH_I (AW),
      .DATA_WIDTH_I (DW),
      .DEPTH        (DEPTH),
      .RESET_PC     (RPC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .data_imem      (data_imem),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .count          (count)
   );

   always #5 clk = ~clk;

   // Memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] memf(input logic [AW-1:0] a);
      return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_9BDF ^ {a, 22'h0};
   endfunction

   // Synchronous instruction memory.
   always @(posedge clk) begin
      if (imem_req) data_imem <= memf(imem_addr);
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: queue of PCs awaiting decode plus the fetch pointer.
   logic [31:0] q_pc[$];
   logic [31:0] m_fpc;
   bit          m_pend;
   logic [31:0] m_ppc;
   bit          m_pop;
   bit          m_req;

   logic          s_req;
   logic [AW-1:0] s_addr;
   logic          s_valid;
   logic [31:0]   s_pc;
   logic [31:0]   s_instr;
   logic [2:0]    s_count;

   task automatic model_reset();
      q_pc.delete();
      m_fpc  = RPC;
      m_pend = 0;
      m_ppc  = '0;
   endtask

   task automatic check_model();
      int          occ;
      logic [31:0] head;
      logic [31:0] fpc;
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = instr_valid;
      s_pc    = instr_pc;
      s_instr = instr;
      s_count = count;
      occ   = q_pc.size();
      m_pop = (occ != 0) && instr_ready && !redirect_valid;
      m_req = fetch_en && !redirect_valid && ((occ + int'(m_pend) - int'(m_pop)) < DEPTH);
      chk("imem_req", imem_req, m_req);
      if (m_req) begin
         fpc = m_fpc;
         chk("imem_addr", imem_addr, fpc[AW+1:2]);
      end
      chk("instr_valid", instr_valid, occ != 0);
      chk("count", count, occ);
      if (occ != 0) begin
         head = q_pc[0];
         chk("instr_pc", instr_pc, head);
         chk("instr", instr, memf(head[AW+1:2]));
      end
   endtask

   task automatic advance_model();
      if (redirect_valid) begin
         q_pc.delete();
         m_pend = 0;
         m_fpc  = {redirect_pc[31:2], 2'b00};
      end else begin
         if (m_pop) void'(q_pc.pop_front());
         if (m_pend) q_pc.push_back(m_ppc);
         if (m_req) begin
            m_ppc = m_fpc;
            m_fpc = m_fpc + 32'd4;
         end
         m_pend = m_req;
      end
   endtask

   // One cycle: drive at the falling edge, check 1 time unit later,
   // step the model across the rising edge, return at the next falling edge.
   task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
      fetch_en       = fe;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      check_model();
      advance_model();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"},   imem_req, 0);
      chk({tag, "_valid"}, instr_valid, 0);
      chk({tag, "_instr"}, instr, 0);
      chk({tag, "_pc"},    instr_pc, 0);
      chk({tag, "_count"}, count, 0);
   endtask

   initial begin
      rst = 1'b1;
      fetch_en = 1'b1;
      instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Startup stream
      step(1, 1, 0, 0);
      chk("start_req", s_req, 1);
      chk("start_addr", s_addr, 0);
      step(1, 1, 0, 0);
      chk("start_valid1", s_valid, 0);
      step(1, 1, 0, 0);
      chk("start_valid2", s_valid, 1);
      chk("start_pc0", s_pc, 32'h0);
      chk("start_instr0", s_instr, 32'h1357_9BDF);
      step(1, 1, 0, 0);
      chk("start_pc4", s_pc, 32'h4);
      step(1, 1, 0, 0);
      chk("start_pc8", s_pc, 32'h8);

      // Backpressure
      repeat (8) step(1, 0, 0, 0);
      chk("bp_count", s_count, 4);
      chk("bp_req", s_req, 0);
      step(1, 1, 0, 0);
      chk("bp_resume0", s_pc, 32'hC);
      step(1, 1, 0, 0);
      chk("bp_resume1", s_pc, 32'h10);
      repeat (8) step(1, 1, 0, 0);

      // fetch_en low: pending read completes, queue drains
      repeat (6) step(0, 1, 0, 0);
      chk("fe_off_empty", s_valid, 0);
      repeat (3) step(1, 1, 0, 0);

      // Redirect with a read to 0x10 in flight, head being accepted
      step(1, 1, 1, 32'h0);
      repeat (5) step(1, 1, 0, 0);
      step(1, 1, 1, 32'h203);
      chk("rd_T_req", s_req, 0);
      chk("rd_T_valid", s_valid, 1);
      step(1, 1, 0, 0);
      chk("rd_T1_count", s_count, 0);
      chk("rd_T1_req", s_req, 1);
      chk("rd_T1_addr", s_addr, 10'h080);
      step(1, 1, 0, 0);
      chk("rd_T2_valid", s_valid, 0);
      step(1, 1, 0, 0);
      chk("rd_T3_valid", s_valid, 1);
      chk("rd_T3_pc", s_pc, 32'h200);

      // Address wrap
      step(1, 1, 1, 32'h0000_0FFC);
      step(1, 1, 0, 0);
      chk("wrap_addr0", s_addr, 10'h3FF);
      step(1, 1, 0, 0);
      chk("wrap_addr1", s_addr, 10'h000);
      step(1, 1, 0, 0);
      chk("wrap_pc0", s_pc, 32'h0000_0FFC);
      step(1, 1, 0, 0);
      chk("wrap_pc1", s_pc, 32'h0000_1000);

      // Reset with three entries queued and a read pending
      step(1, 0, 1, 32'h40);
      repeat (4) step(1, 0, 0, 0);
      fetch_en = 1'b1;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check_model();
      chk("mr_count", s_count, 3);
      #1;
      rst = 1'b1;
      fetch_en = 1'b0;
      #1;
      check_reset_outputs("mr");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(1, 1, 0, 0);
      chk("mr_req", s_req, 1);
      chk("mr_addr", s_addr, 0);
      step(1, 1, 0, 0);
      chk("mr_novalid", s_valid, 0);
      step(1, 1, 0, 0);
      chk("mr_pc0", s_pc, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rv32_fetch_queue.md
Name: rv32_fetch_queue

Overview:
Parametrised prefetching instruction-fetch unit for the next-generation ROC core. It replaces the single FETCH/DECODE handshake of the multi-cycle core. It streams word-addressed reads from a synchronous instruction memory into a DEPTH-entry queue of {pc, instr} pairs, delivered to decode over a valid/ready handshake. It also accepts redirects from branch, jump, trap and mret, which flush the queue and discard any in-flight read.

Parameters:
ADDR_WIDTH_I, 10, instruction memory word-address width
DATA_WIDTH_I, 32, instruction word width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch byte address after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
fetch_en  in  1  allows new imem requests; does not gate delivery or redirect
imem_req  out  1  imem read enable; data returns the next cycle
imem_addr  out  ADDR_WIDTH_I  word address, fetch_pc[ADDR_WIDTH_I+1:2]
data_imem  in  DATA_WIDTH_I  imem read data, valid the cycle after imem_req
instr_valid  out  1  queue head valid
instr_ready  in  1  decode accepts head
instr  out  DATA_WIDTH_I  head instruction
instr_pc  out  32  head byte PC
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  restart byte PC; bits [1:0] forced to 0
count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC, pending=0, queue empty.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, count=0.
- State:
  - fetch_pc: next byte address to request.
  - pending: a read was issued last cycle.
  - pending_pc: PC of that read.
- Pop: pop = instr_valid && instr_ready && !redirect_valid.
- Issue:
  - imem_req = fetch_en && !redirect_valid && (count + pending - pop) < DEPTH.
  - This credit rule makes overflow impossible and sustains 1 instr/cycle with DEPTH >= 2 and instr_ready held high.
- On an issue:
  - pending <= 1, pending_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
  - fetch_pc increments with 32-bit wrap; imem_addr simply truncates.
- Response:
  - When pending=1 and no redirect this cycle, push {pending_pc, data_imem} at the clock edge.
  - The pushed entry is visible on instr/instr_pc the following cycle; there is no bypass.
- Redirect (redirect_valid=1 in cycle T):
  - At the edge: queue cleared, pending cleared (the T response is dropped), fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No request in T. First request at T+1, data T+2, instr_valid at T+3.
- Simultaneous events:
  - Redirect beats pop and push.
  - Push and pop in the same cycle leave count unchanged.
  - fetch_en=0 finishes the pending read, and the queue still drains.
- Output when empty: instr/instr_pc hold the last head contents (don't-care); only instr_valid is meaningful.
- instr_valid = (count != 0). All outputs except imem_req/imem_addr are registered or queue-derived.
- Reset mid-operation discards everything; there are no stale pushes after rst falls.

Decomposition:
- fetch_pkg:
  - typedef fetch_entry_t packed struct {logic [31:0] pc; logic [DATA_WIDTH_I-1:0] instr;} (width fixed at 32 in the package).
  - localparam FETCH_STEP = 32'd4.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t, DEPTH entries.
  - Pointers with wrap bit, synchronous flush input, count output.
  - Async active-high reset.

Test Plan:
- Reset release, fetch_en=1, instr_ready=1:
  - imem_req=1 with imem_addr=0 in the first cycle; instr_pc 0,4,8,… on consecutive cycles; instr matches the memory model.
  - One instruction per cycle after 2-cycle fill.
- Backpressure:
  - instr_ready=0 with DEPTH=4: count saturates at 4, imem_req drops, no request issued while full.
  - Release ready: pcs resume contiguous with none lost or duplicated.
- Redirect at T with a read pending to pc 0x10 and redirect_pc=0x203:
  - Entry 0x10 never appears, queue empties at T+1.
  - imem_addr=0x80 at T+1; instr_pc=0x200 with instr_valid at T+3.
- Redirect simultaneous with instr_valid=instr_ready=1: the head is not considered consumed and count=0 next cycle.
- Wrap: redirect_pc=0x0000_0FFC with ADDR_WIDTH_I=10:
  - imem_addr=0x3FF then 0x000.
  - instr_pc=0xFFC then 0x1000 (PC not truncated).
- Assert rst while count=3 and pending=1: all outputs zero immediately; after release, fetch restarts at RESET_PC with no stale entries.
